// File: rtl/emmc_traffic_gen_if.sv
// emmc_traffic_gen_if: user-port bundle between the traffic generator and emmc_sm.
//  master (generator): drives we_o, start_o, blk_cnt_o, dat_o; receives dat_i, dvalid_i, ready_i.
//  slave  (emmc_sm side / bench model): the mirror image.
interface emmc_traffic_gen_if #(
  parameter int unsigned DAT_W = 8
) ();
  logic             we_o;
  logic             start_o;
  logic [31:0]      blk_cnt_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             dvalid_i;
  logic             ready_i;

  modport master (
    output we_o, start_o, blk_cnt_o, dat_o,
    input  dat_i, dvalid_i, ready_i
  );

  modport slave (
    input  we_o, start_o, blk_cnt_o, dat_o,
    output dat_i, dvalid_i, ready_i
  );
endinterface

// File: rtl/emmc_traffic_gen.sv
// emmc_traffic_gen: write/read-back traffic generator and checker for the emmc_sm user port.
//  Each pass writes BLK_CNT*BLK_BYTES beats of a known pattern, reads them back and
//  counts mismatching beats. Reports pass/fail, error count, first failing beat and watchdog timeout.
// Ports:
//  clk_i, arst_i          clock, async active-high reset
//  go_i                   rising edge in IDLE starts a run; low in DONE returns to IDLE
//  mode_i                 0/3 write+verify, 1 write only, 2 read/verify only (sampled at run start)
//  bus (master)           we_o, start_o, blk_cnt_o, dat_o out; dat_i, dvalid_i, ready_i in
//  busy_o, done_o, pass_o, timeout_o, err_cnt_o, first_err_addr_o, pass_cnt_o  run status
// The LFSR pattern is the 8-bit polynomial x^8+x^6+x^5+x^4+1 on the low byte; DAT_W must be >= 8.
module emmc_traffic_gen #(
  parameter int unsigned      DAT_W       = 8,
  parameter int unsigned      BLK_BYTES   = 512,
  parameter int unsigned      BLK_CNT     = 1,
  parameter int unsigned      PATTERN     = 0,
  parameter logic [DAT_W-1:0] SEED        = DAT_W'(1),
  parameter int unsigned      N_PASSES    = 1,
  parameter int unsigned      TIMEOUT_CYC = 2**20
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                go_i,
  input  logic [1:0]          mode_i,
  emmc_traffic_gen_if.master  bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [31:0]         err_cnt_o,
  output logic [31:0]         first_err_addr_o,
  output logic [15:0]         pass_cnt_o
);

  localparam int unsigned TOTAL   = BLK_CNT * BLK_BYTES;
  localparam logic [31:0] LAST_BT = 32'(TOTAL - 1);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CMD, S_WR_DAT, S_WR_END,
    S_RD_CMD, S_RD_DAT, S_RD_END, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             go_prev_q, go_prev_d;
  logic [1:0]       mode_q, mode_d;
  logic             start_q, start_d;
  logic             we_q, we_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [DAT_W-1:0] exp_q, exp_d;
  logic [31:0]      beat_q, beat_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      run_pass_q, run_pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      err_q, err_d;
  logic [31:0]      first_q, first_d;
  logic [15:0]      pass_cnt_q, pass_cnt_d;
  logic             wait_st;

  // Next pattern value: 8-bit Fibonacci LFSR or wrapping increment.
  function automatic logic [DAT_W-1:0] pat_step(input logic [DAT_W-1:0] v);
    logic [7:0] l;
    l = v[7:0];
    if (PATTERN == 1) return DAT_W'({l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]});
    return v + DAT_W'(1);
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    go_prev_d  = go_i;
    mode_d     = mode_q;
    dat_d      = dat_q;
    exp_d      = exp_q;
    beat_d     = beat_q;
    wd_d       = wd_q + 32'd1;
    run_pass_d = run_pass_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_cnt_d = pass_cnt_q;
    we_d       = we_q;

    wait_st = (state_q != S_IDLE) && (state_q != S_NEXT) && (state_q != S_DONE);

    case (state_q)
      S_IDLE: begin
        if (go_i && !go_prev_q) begin
          mode_d     = mode_i;
          timeout_d  = 1'b0;
          err_d      = '0;
          first_d    = '1;
          pass_cnt_d = '0;
          run_pass_d = '0;
          state_d    = (mode_i == 2'd2) ? S_RD_CMD : S_WR_CMD;
        end
      end
      S_WR_CMD: if (bus.ready_i) state_d = S_WR_DAT;
      S_WR_DAT: begin
        if (bus.ready_i) begin
          wd_d   = '0;
          dat_d  = pat_step(dat_q);
          beat_d = beat_q + 32'd1;
          if (beat_q == LAST_BT) state_d = S_WR_END;
        end
      end
      S_WR_END: if (bus.ready_i && !start_q) state_d = (mode_q == 2'd1) ? S_NEXT : S_RD_CMD;
      S_RD_CMD: if (bus.ready_i) state_d = S_RD_DAT;
      S_RD_DAT: begin
        if (bus.dvalid_i) begin
          wd_d   = '0;
          exp_d  = pat_step(exp_q);
          beat_d = beat_q + 32'd1;
          if (bus.dat_i != exp_q) begin
            if (err_q != '1) err_d = err_q + 32'd1;
            if (first_q == '1) first_d = beat_q;
          end
          if (beat_q == LAST_BT) state_d = S_RD_END;
        end
      end
      S_RD_END: if (bus.ready_i && !start_q) state_d = S_NEXT;
      S_NEXT: begin
        pass_cnt_d = pass_cnt_q + 16'd1;
        run_pass_d = run_pass_q + 32'd1;
        if ((N_PASSES != 0 && (run_pass_q + 32'd1) == 32'(N_PASSES)) ||
            (N_PASSES == 0 && (!go_i || err_q != '0)))
          state_d = S_DONE;
        else
          state_d = (mode_q == 2'd2) ? S_RD_CMD : S_WR_CMD;
      end
      S_DONE: if (!go_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog: any wait state stalled too long aborts the run.
    if (wait_st && wd_q == WD_LAST) begin
      timeout_d = 1'b1;
      state_d   = S_DONE;
    end
    if (!wait_st || state_d != state_q) wd_d = '0;

    // Pattern and beat index restart at the start of every write and read phase.
    if (state_d == S_WR_CMD && state_q != S_WR_CMD) begin
      dat_d  = SEED;
      beat_d = '0;
    end
    if (state_d == S_RD_CMD && state_q != S_RD_CMD) begin
      exp_d  = SEED;
      beat_d = '0;
    end

    case (state_d)
      S_WR_CMD, S_WR_DAT, S_WR_END: we_d = 1'b1;
      S_RD_CMD, S_RD_DAT, S_RD_END: we_d = 1'b0;
      default:                      we_d = we_q;
    endcase

    start_d = (state_d == S_WR_CMD) || (state_d == S_RD_CMD);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    // done holds through IDLE until the next run leaves IDLE.
    done_d  = (state_d == S_DONE) || (done_q && state_d == S_IDLE);
    pass_d  = done_d && (err_d == '0) && !timeout_d;
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= S_IDLE;
      go_prev_q  <= 1'b0;
      mode_q     <= 2'd0;
      start_q    <= 1'b0;
      we_q       <= 1'b0;
      dat_q      <= SEED;
      exp_q      <= SEED;
      beat_q     <= '0;
      wd_q       <= '0;
      run_pass_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      first_q    <= '1;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      go_prev_q  <= go_prev_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
      exp_q      <= exp_d;
      beat_q     <= beat_d;
      wd_q       <= wd_d;
      run_pass_q <= run_pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign bus.we_o         = we_q;
  assign bus.start_o      = start_q;
  assign bus.blk_cnt_o    = 32'(BLK_CNT);
  assign bus.dat_o        = dat_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = first_q;
  assign pass_cnt_o       = pass_cnt_q;

endmodule
